// File: rtl/airlock_sequencer.sv
// airlock_sequencer: two-door airlock controller with pump phases, request arbitration and tick-based phase timing
module airlock_sequencer #(
    parameter int PUMP_TICKS = 5,
    parameter int DOOR_TICKS = 3,
    parameter int TW         = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic hold,
    input  logic req_in2out,
    input  logic req_out2in,
    output logic inner_open,
    output logic outer_open,
    output logic pump_fill,
    output logic pump_drain,
    output logic pressurized,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, FILL, DRAIN, OPEN_IN, OPEN_OUT} state_t;
    state_t state, state_n;
    logic [TW-1:0] cnt, cnt_n;
    logic dir, dir_n;
    logic pend_i2o, pend_o2i, pi_n, po_n, press_n;
    logic adv, done, eff_i, eff_o, serve_i, serve_o;
    // Arbitration in IDLE, phase countdown and sequencing; dir=1 means an in2out transit
    always_comb begin
        adv     = tick & ~hold;
        done    = adv && cnt == ((state == FILL || state == DRAIN) ? TW'(PUMP_TICKS - 1) : TW'(DOOR_TICKS - 1));
        eff_i   = pend_i2o | req_in2out;
        eff_o   = pend_o2i | req_out2in;
        serve_i = eff_i & (~eff_o | pressurized);
        serve_o = eff_o & ~serve_i;
        state_n = state;
        cnt_n   = adv ? cnt + 1'b1 : cnt;
        dir_n   = dir;
        pi_n    = eff_i;
        po_n    = eff_o;
        press_n = pressurized;
        if (state == IDLE) begin
            cnt_n = '0;
            if (serve_i) begin
                state_n = pressurized ? OPEN_IN : FILL;
                dir_n   = 1'b1;
                pi_n    = 1'b0;
            end else if (serve_o) begin
                state_n = pressurized ? DRAIN : OPEN_OUT;
                dir_n   = 1'b0;
                po_n    = 1'b0;
            end
        end else if (done) begin
            cnt_n   = '0;
            press_n = state == FILL ? 1'b1 : state == DRAIN ? 1'b0 : pressurized;
            state_n = state == FILL    ? OPEN_IN :
                      state == DRAIN   ? OPEN_OUT :
                      state == OPEN_IN ? (dir ? DRAIN : IDLE) :
                                         (dir ? IDLE : FILL);
        end
    end
    // State register; reset drops every actuator immediately and forgets pending requests
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dir         <= 1'b0;
            pend_i2o    <= 1'b0;
            pend_o2i    <= 1'b0;
            pressurized <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dir         <= dir_n;
            pend_i2o    <= pi_n;
            pend_o2i    <= po_n;
            pressurized <= press_n;
        end
    end
    assign inner_open = state == OPEN_IN;
    assign outer_open = state == OPEN_OUT;
    assign pump_fill  = state == FILL;
    assign pump_drain = state == DRAIN;
    assign busy       = state != IDLE;
endmodule

// File: doc/airlock_sequencer.md
Name: airlock_sequencer

Overview:
- Controls the airlock chamber of the interlock system: two doors (inner and outer) and one pump (fill or drain).
- Accepts transit requests from both sides, decides which one to serve, and runs the door and pump phases in order.
- All phase durations are counted in ticks. A tick is the 1-cycle enable strobe from the team's free-running divider counter.
- Guarantees the interlock invariant: never both doors open, and never a door open while the pump runs.

Parameters:
- PUMP_TICKS, 5, ticks per fill or drain phase (must be ≥1).
- DOOR_TICKS, 3, ticks a door stays open (must be ≥1).
- TW, 8, phase-counter width. PUMP_TICKS and DOOR_TICKS must each be ≤ 2^TW.

Ports:
- clock, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low. reset=0 forces the reset state immediately; normal operation resumes on the first clock edge after reset returns to 1.
- tick, input, 1: 1-cycle strobe from the divider counter.
- hold, input, 1: level. While 1, ticks are ignored and the timer freezes.
- req_in2out, input, 1: 1-cycle pulse; a user on the inner side wants to go out.
- req_out2in, input, 1: 1-cycle pulse; a user on the outer side wants to come in.
- inner_open, output, 1: inner-door open command.
- outer_open, output, 1: outer-door open command.
- pump_fill, output, 1: pressurize the chamber.
- pump_drain, output, 1: depressurize the chamber.
- pressurized, output, 1: chamber is at inner-side level.
- busy, output, 1: FSM is not in IDLE.

Behaviour:
- Reset values:
  - FSM state = IDLE, phase counter = 0, pending flags = 0.
  - pressurized = 1.
  - inner_open, outer_open, pump_fill, pump_drain, busy all 0.
- FSM states: IDLE, FILL, DRAIN, OPEN_IN, OPEN_OUT.
- Outputs are Moore and decoded from the registered state: FILL→pump_fill, DRAIN→pump_drain, OPEN_IN→inner_open, OPEN_OUT→outer_open.
- busy = (state != IDLE).
- Phase timing:
  - The counter is set to 0 on entry to every phase.
  - Advance condition for a phase: tick & ~hold & cnt == N-1, where N = PUMP_TICKS or DOOR_TICKS. On that edge the FSM moves to the next phase.
  - Otherwise, on each tick & ~hold, cnt increments.
  - Result: each phase spans exactly N qualifying ticks.
  - A tick with hold=1 is discarded, not deferred.
- pressurized updates on exit from a pump phase: it is set to 1 when FILL completes and cleared to 0 when DRAIN completes.
- Transit sequences:
  - in2out: [FILL if ~pressurized] → OPEN_IN → DRAIN → OPEN_OUT → IDLE.
  - out2in: [DRAIN if pressurized] → OPEN_OUT → FILL → OPEN_IN → IDLE.
- Request capture:
  - Each request pulse sets a sticky pending flag, pend_i2o or pend_o2i.
  - A request pulse that coincides with a re-pulse of an already-pending side has no extra effect (no counting).
- Arbitration, in IDLE only:
  - eff_i2o = pend_i2o | req_in2out; eff_o2i likewise.
  - One side effective: start that transit on this edge and clear its pending flag.
  - Both sides effective: serve the side whose door matches the current chamber level, so no pump phase is needed. pressurized=1 → in2out; pressurized=0 → out2in. The loser's pending flag is set or kept.
  - Starting from IDLE takes 0 extra cycles: the FSM leaves IDLE on the same edge the request is sampled.
- During a transit, new requests only set pending flags. At the final phase exit the FSM goes to IDLE for at least one cycle before arbitrating again.
- hold may assert in any state. Outputs remain unchanged and only timing is frozen; in IDLE, hold does not block arbitration.
- Reset mid-transit: doors and pump deassert asynchronously, pending requests are lost, and pressurized returns to 1.
- Invariant: at most one of the four actuator outputs is high in any cycle.

Test Plan:
- Reset check: drive reset=0 mid-stream → all actuators and busy read 0, pressurized=1, regardless of clock.
- Single in2out (PUMP_TICKS=3, DOOR_TICKS=2, tick every cycle, pressurized=1), pulse req_in2out → inner_open 2 cycles, pump_drain 3, outer_open 2, then IDLE with pressurized=0; busy high for exactly 7 cycles.
- Pump-first out2in: from pressurized=1, pulse req_out2in → drain 3, outer 2, fill 3, inner 2; busy high for 10 cycles; ends with pressurized=1.
- Simultaneous requests: pulse both in the same cycle with pressurized=1 → in2out runs first (7 cycles), then 1 IDLE cycle, then out2in with no drain: outer 2, fill 3, inner 2.
- Hold and sparse ticks: tick once every 4 cycles; hold=1 for 5 ticks during DRAIN → pump_drain lasts 8 tick periods, the other outputs stay 0, and the sequence afterwards is unchanged.
- Mid-transit reset: assert reset during OPEN_OUT with pend_o2i set → outputs drop without a clock edge; after release the FSM stays in IDLE (pending cleared). Check the actuator invariant on every cycle of every test.
